// File: rtl/pseudo_spi_rx.sv
// Serial-to-parallel loader: rebuilds MSB-first bytes from the two-phase
// SCLK1/SCLK2/LAT/SO stream and writes them into an 8x512 SRAM.
module pseudo_spi_rx #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int RESERVED_DATA_LEN = 8,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                         CLK,
    input  logic                         rst_n,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
    input  logic                         SCLK1,
    input  logic                         SCLK2,
    input  logic                         LAT,
    input  logic                         SPI_SI,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic [MEMORY_DATA_WIDTH-1:0] D,
    output logic                         D_WE,
    output logic                         CEN,
    output logic                         spi_is_done,
    output logic                         ERR,
    output logic [1:0]                   dbg_state
);

    localparam int DW  = MEMORY_DATA_WIDTH;
    localparam int AW  = MEMORY_ADDR_WIDTH;
    localparam int LW  = RESERVED_DATA_LEN;
    localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk1_sync, sclk2_sync, lat_sync, si_sync;
    logic                   sclk1_prev, sclk2_prev, lat_prev;
    logic                   sclk1_rise, sclk2_rise, lat_rise, si_bit;

    logic [AW-1:0]  addr_cnt, last_a;
    logic [LW-1:0]  byte_cnt;
    logic [BCW-1:0] bit_cnt;
    logic [DW-1:0]  shreg, last_d;
    logic           err_q;
    logic           sclk1_seen, sclk2_seen;

    logic start, active, lat_hit, shift_en, byte_full;

    // Oldest synchronizer stage sits in the MSB; the extra *_prev flop gives edge detect.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sclk1_sync <= '0;
            sclk2_sync <= '0;
            lat_sync   <= '0;
            si_sync    <= '0;
            sclk1_prev <= 1'b0;
            sclk2_prev <= 1'b0;
            lat_prev   <= 1'b0;
        end else begin
            sclk1_sync <= SYNC_STAGES'({sclk1_sync, SCLK1});
            sclk2_sync <= SYNC_STAGES'({sclk2_sync, SCLK2});
            lat_sync   <= SYNC_STAGES'({lat_sync, LAT});
            si_sync    <= SYNC_STAGES'({si_sync, SPI_SI});
            sclk1_prev <= sclk1_sync[SYNC_STAGES-1];
            sclk2_prev <= sclk2_sync[SYNC_STAGES-1];
            lat_prev   <= lat_sync[SYNC_STAGES-1];
        end
    end

    assign sclk1_rise = sclk1_sync[SYNC_STAGES-1] & ~sclk1_prev;
    assign sclk2_rise = sclk2_sync[SYNC_STAGES-1] & ~sclk2_prev;
    assign lat_rise   = lat_sync[SYNC_STAGES-1] & ~lat_prev;
    assign si_bit     = si_sync[SYNC_STAGES-1];

    assign start     = (state == IDLE) && BGN;
    assign active    = (state == RECV) || (state == WRITE);
    // A frame latch mid-byte wins over a coincident data edge: the byte is restarted.
    assign lat_hit   = (state == RECV) && lat_rise && (bit_cnt != '0);
    assign shift_en  = (state == RECV) && sclk2_rise && !lat_hit;
    assign byte_full = shift_en && (bit_cnt == LAST_BIT);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        D_WE        = 1'b0;
        CEN         = 1'b1;
        A           = last_a;
        D           = last_d;
        spi_is_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (BGN) state_next = RECV;
            end
            RECV: begin
                if (!BGN)           state_next = IDLE;
                else if (byte_full) state_next = WRITE;
            end
            WRITE: begin
                D_WE = 1'b1;
                CEN  = 1'b0;
                A    = addr_cnt;
                D    = shreg;
                if (!BGN)                state_next = IDLE;
                else if (byte_cnt == '0) state_next = DONE;
                else                     state_next = RECV;
            end
            DONE: begin
                spi_is_done = 1'b1;
                if (!BGN) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt   <= '0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            last_a     <= '0;
            last_d     <= '0;
            err_q      <= 1'b0;
            sclk1_seen <= 1'b0;
            sclk2_seen <= 1'b0;
        end else if (start) begin
            addr_cnt   <= ADDR_BGN;
            byte_cnt   <= DATA_LEN;
            bit_cnt    <= '0;
            err_q      <= 1'b0;
            sclk1_seen <= 1'b0;
            sclk2_seen <= 1'b0;
        end else if (active) begin
            // Two SCLK2 edges without an SCLK1 edge between them is a protocol error.
            if (sclk2_rise) begin
                if (sclk2_seen && !sclk1_seen && !sclk1_rise) err_q <= 1'b1;
                sclk2_seen <= 1'b1;
                sclk1_seen <= 1'b0;
            end else if (sclk1_rise) begin
                sclk1_seen <= 1'b1;
            end

            if (lat_hit) begin
                err_q   <= 1'b1;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= {shreg[DW-2:0], si_bit};
                bit_cnt <= byte_full ? '0 : bit_cnt + 1'b1;
            end

            if (state == WRITE) begin
                last_a <= addr_cnt;
                last_d <= shreg;
                if (BGN && (byte_cnt != '0)) begin
                    byte_cnt <= byte_cnt - 1'b1;
                    addr_cnt <= addr_cnt + 1'b1;
                end
            end
        end
    end

    assign ERR       = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_pseudo_spi_rx.sv
// Bench for pseudo_spi_rx: drives the two-phase serial stream and checks the
// SRAM write log against a per-transfer expected queue.
module tb_pseudo_spi_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       bgn;
  logic [8:0] addr_bgn;
  logic [7:0] data_len;
  logic       sclk1, sclk2, lat, spi_si;
  logic [8:0] a;
  logic [7:0] d;
  logic       d_we, cen, done, err;
  logic [1:0] dbg_state;

  pseudo_spi_rx dut (
    .CLK(clk), .rst_n(rst_n), .BGN(bgn), .ADDR_BGN(addr_bgn), .DATA_LEN(data_len),
    .SCLK1(sclk1), .SCLK2(sclk2), .LAT(lat), .SPI_SI(spi_si),
    .A(a), .D(d), .D_WE(d_we), .CEN(cen), .spi_is_done(done), .ERR(err),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  tx_q[$];

  // write monitor
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_we_cyc = -100;
  int          done_gap = 0;
  int          wide_we = 0;
  int          cen_bad = 0;
  logic [16:0] wr_log[0:255];
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (d_we === 1'b1) begin
      wr_log[wr_cnt[7:0]] <= {a, d};
      wr_cnt <= wr_cnt + 1;
      last_we_cyc <= cyc;
      if (prev_we === 1'b1) wide_we <= wide_we + 1;
    end
    if (cen !== ~d_we) cen_bad <= cen_bad + 1;
    if (done === 1'b1 && prev_done !== 1'b1) done_gap <= cyc - last_we_cyc;
    prev_we <= d_we;
    prev_done <= done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic skip_s1);
    int ph;
    ph = $urandom_range(4, 6);
    spi_si = b;
    if (!skip_s1) begin
      sclk1 = 1'b1;
      cycles(ph);
      sclk1 = 1'b0;
    end
    cycles(ph);
    sclk2 = 1'b1;
    cycles(ph);
    sclk2 = 1'b0;
    cycles(ph);
  endtask

  task automatic send_byte(input logic [7:0] b, input int skip_idx);
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == skip_idx);
  endtask

  task automatic send_all();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], -1);
  endtask

  task automatic lat_pulse();
    lat = 1'b1;
    cycles(5);
    lat = 1'b0;
    cycles(5);
  endtask

  task automatic fill_random(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // reference model: byte i of the image lands at (first + i) mod 512
  task automatic model_writes(input logic [8:0] first, input int n);
    logic [31:0] ea;
    for (int i = 0; i < n; i++) begin
      ea = (32'(first) + 32'(i)) % 512;
      exp_q.push_back({ea[8:0], tx_q[i]});
    end
  endtask

  task automatic compare_writes(input string tag, input int base);
    int got;
    int n;
    logic [16:0] e;
    logic [31:0] obs;
    got = wr_cnt - base;
    n = exp_q.size();
    check({tag, "_count"}, 32'(got), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      obs = (i < got) ? 32'(wr_log[8'(base + i)]) : 32'hdeadbeef;
      check({tag, "_wr"}, obs, 32'(e));
    end
  endtask

  task automatic start(input logic [8:0] ad, input logic [7:0] len);
    addr_bgn = ad;
    data_len = len;
    bgn = 1'b1;
    cycles(3);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic finish_transfer(input string tag, input int base, input logic exp_err);
    wait_done(tag);
    cycles(2);
    compare_writes(tag, base);
    check({tag, "_done_gap"}, 32'(done_gap), 32'd1);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    bgn = 1'b0;
    cycles(3);
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic run_transfer(input string tag, input logic [8:0] ad);
    int base;
    base = wr_cnt;
    model_writes(ad, tx_q.size());
    start(ad, 8'(tx_q.size() - 1));
    send_all();
    finish_transfer(tag, base, 1'b0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    bgn = 1'b0;
    addr_bgn = '0;
    data_len = '0;
    sclk1 = 1'b0;
    sclk2 = 1'b0;
    lat = 1'b0;
    spi_si = 1'b0;
    cycles(3);
    check("rst_a", 32'(a), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_we", 32'(d_we), 32'd0);
    check("rst_cen", 32'(cen), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    cycles(3);

    // loopback image
    tx_q = '{8'hAB, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h05, 8'h3D, 8'h9E,
             8'hC3, 8'hD7, 8'h58, 8'h7A, 8'h01, 8'hC2};
    run_transfer("loop", 9'h020);

    tx_q = '{8'h96};
    run_transfer("single", 9'h1A5);

    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_transfer("wrap", 9'h1FE);

    // framing: latch after 5 bits discards the partial byte
    base = wr_cnt;
    tx_q = '{8'h5A};
    model_writes(9'h0C0, 1);
    start(9'h0C0, 8'd0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    lat_pulse();
    send_byte(8'h5A, -1);
    finish_transfer("frame", base, 1'b1);

    // abort after 2 of 4 bytes; one SCLK1 is missing in the first byte
    base = wr_cnt;
    fill_random(4);
    model_writes(9'h040, 2);
    start(9'h040, 8'd3);
    send_byte(tx_q[0], 4);
    send_byte(tx_q[1], -1);
    cycles(4);
    bgn = 1'b0;
    cycles(3);
    compare_writes("abort", base);
    check("abort_idle", 32'(dbg_state), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err_sticky", 32'(err), 32'd1);
    cycles(10);
    check("abort_no_late_wr", 32'(wr_cnt - base), 32'd2);
    fill_random(2);
    base = wr_cnt;
    model_writes(9'h150, 2);
    start(9'h150, 8'd1);
    check("restart_err_clr", 32'(err), 32'd0);
    send_all();
    finish_transfer("restart", base, 1'b0);

    // reset in the middle of the fourth bit
    base = wr_cnt;
    start(9'h100, 8'd2);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    spi_si = 1'b1;
    sclk1 = 1'b1;
    cycles(5);
    sclk1 = 1'b0;
    cycles(5);
    sclk2 = 1'b1;
    cycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(d_we), 32'd0);
    check("mid_rst_cen", 32'(cen), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_a", 32'(a), 32'd0);
    check("mid_rst_d", 32'(d), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    sclk2 = 1'b0;
    bgn = 1'b0;
    cycles(4);
    rst_n = 1'b1;
    cycles(4);
    check("mid_rst_no_wr", 32'(wr_cnt - base), 32'd0);
    fill_random(3);
    run_transfer("post_rst", 9'($urandom_range(0, 511)));

    // random images at random start addresses
    for (int t = 0; t < 4; t++) begin
      fill_random($urandom_range(1, 5));
      run_transfer("rand", 9'($urandom_range(0, 511)));
    end

    check("we_one_cycle", 32'(wide_we), 32'd0);
    check("cen_vs_we", 32'(cen_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
